fifo_sync_prog: RTL and testbench

Parametrised successor to the UART-AXI bridge synchronous FIFO. It adds the following:
- selectable first-word-fall-through (FWFT) or registered read mode;
- runtime-programmable almost-full/almost-empty thresholds;
- a free-space output;
- sticky overflow/underflow error flags;
- a synchronous flush;
- a high-watermark counter.

It sits between the UART RX/TX byte paths and the frame parser/builder. It is also intended as the generic buffer for wider AXI data channels.

---
 rtl/fifo_sync_prog.sv | 176 +++++++++++++++++
 tb/tb_fifo_sync_prog.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog.sv
// ---------------------------------------------------------------------------
// fifo_sync_prog
// Single-clock FIFO with selectable read mode (first-word-fall-through or
// registered), runtime-programmable almost-full/almost-empty thresholds,
// free-space output, sticky overflow/underflow flags, synchronous flush and
// a high-watermark occupancy counter. Depth need not be a power of two.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              discard all contents next cycle (stats preserved)
//   wr_en, wr_data     write request / data; full = count == FIFO_DEPTH
//   rd_en, rd_data     read request / data
//   rd_valid           FWFT=1: !empty; FWFT=0: one-cycle pulse after a read
//   empty              count == 0
//   af_thresh          almost_full  = count >= af_thresh
//   ae_thresh          almost_empty = count <= ae_thresh
//   count, free        occupancy and FIFO_DEPTH - occupancy
//   overflow           sticky: write attempted while full
//   underflow          sticky: read attempted while empty
//   max_count          highest occupancy since reset / last clr_stat
//   clr_stat           clears overflow, underflow; reloads max_count
// ---------------------------------------------------------------------------
module fifo_sync_prog #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 64,
   parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
   parameter int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1,
   parameter bit FWFT        = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   output logic                   full,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   rd_valid,
   output logic                   empty,
   input  logic [COUNT_WIDTH-1:0] af_thresh,
   input  logic [COUNT_WIDTH-1:0] ae_thresh,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [COUNT_WIDTH-1:0] count,
   output logic [COUNT_WIDTH-1:0] free,
   output logic                   overflow,
   output logic                   underflow,
   output logic [COUNT_WIDTH-1:0] max_count,
   input  logic                   clr_stat
);

   localparam logic [COUNT_WIDTH-1:0] DEPTH_C  = COUNT_WIDTH'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0]  LAST_PTR = ADDR_WIDTH'(FIFO_DEPTH - 1);

   logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]  wr_ptr;
   logic [ADDR_WIDTH-1:0]  rd_ptr;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_next;
   logic [COUNT_WIDTH-1:0] max_q;
   logic                   wr_acc;
   logic                   rd_acc;
   logic                   overflow_q;
   logic                   underflow_q;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
   endfunction

   // Status flags are pure decodes of the count register.
   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_full  = (count_q >= af_thresh);
   assign almost_empty = (count_q <= ae_thresh);
   assign count        = count_q;
   assign free         = DEPTH_C - count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign max_count    = max_q;

   // Acceptance uses the registered flags only: a write while full is dropped
   // even if a read frees a slot in the same cycle, and vice versa.
   assign wr_acc = wr_en && !full  && !flush;
   assign rd_acc = rd_en && !empty && !flush;

   always_comb begin
      // NOTE: default first so every path assigns count_next (no latch).
      count_next = count_q;
      if (flush)
         count_next = '0;
      else if (wr_acc && !rd_acc)
         count_next = count_q + COUNT_WIDTH'(1);
      else if (rd_acc && !wr_acc)
         count_next = count_q - COUNT_WIDTH'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         max_q       <= '0;
      end else begin
         count_q <= count_next;

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         end

         // A new error event beats a simultaneous clear.
         if (wr_en && full && !flush)
            overflow_q <= 1'b1;
         else if (clr_stat)
            overflow_q <= 1'b0;

         if (rd_en && empty && !flush)
            underflow_q <= 1'b1;
         else if (clr_stat)
            underflow_q <= 1'b0;

         // Clearing restarts the watermark from the occupancy being entered.
         if (clr_stat || (count_next > max_q))
            max_q <= count_next;
      end
   end

   // NOTE: storage is deliberately not reset; pointers/count define validity.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= wr_data;
   end

   generate
      if (FWFT) begin : g_fwft
         assign rd_data  = mem[rd_ptr];
         assign rd_valid = !empty;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] rd_data_q;
         logic                  rd_valid_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               // rd_acc is already low during flush, so the pulse is squashed.
               rd_valid_q <= rd_acc;
               if (rd_acc)
                  rd_data_q <= mem[rd_ptr];
            end
         end

         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

`ifdef ENABLE_FIFO_ASSERTIONS
   a_count_range : assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
   a_not_both    : assert property (@(posedge clk) disable iff (rst) !(empty && full));
   a_count_free  : assert property (@(posedge clk) disable iff (rst)
                                    (COUNT_WIDTH + 1)'(count_q) + (COUNT_WIDTH + 1)'(free)
                                    == (COUNT_WIDTH + 1)'(FIFO_DEPTH));
   a_rd_pulse    : assert property (@(posedge clk) disable iff (rst)
                                    (!FWFT && rd_valid) |-> $past(rd_acc));
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_prog
// Directed bench for fifo_sync_prog. Three instances:
//   u_a : FWFT=1, depth 64  (fill/drain, thresholds, overflow, flush, stats)
//   u_b : FWFT=0, depth 64  (registered read timing)
//   u_c : FWFT=1, depth 5   (non-power-of-two wrap, mid-burst reset)
// Inputs change 1 time unit after posedge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_fifo_sync_prog;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- instance A: FWFT=1, depth 64 ----------------
   logic       a_rst = 1'b1, a_flush = 1'b0, a_wr_en = 1'b0, a_rd_en = 1'b0, a_clr = 1'b0;
   logic [7:0] a_wr_data = '0, a_rd_data;
   logic [6:0] a_af = 7'd64, a_ae = 7'd0, a_count, a_free, a_max;
   logic       a_full, a_empty, a_rd_valid, a_almost_full, a_almost_empty, a_overflow, a_underflow;

   fifo_sync_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(64), .FWFT(1'b1)) u_a (
      .clk(clk), .rst(a_rst), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
      .full(a_full), .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
      .empty(a_empty), .af_thresh(a_af), .ae_thresh(a_ae), .almost_full(a_almost_full),
      .almost_empty(a_almost_empty), .count(a_count), .free(a_free), .overflow(a_overflow),
      .underflow(a_underflow), .max_count(a_max), .clr_stat(a_clr));

   // ---------------- instance B: FWFT=0, depth 64 ----------------
   logic       b_rst = 1'b1, b_flush = 1'b0, b_wr_en = 1'b0, b_rd_en = 1'b0, b_clr = 1'b0;
   logic [7:0] b_wr_data = '0, b_rd_data;
   logic [6:0] b_af = 7'd64, b_ae = 7'd0, b_count, b_free, b_max;
   logic       b_full, b_empty, b_rd_valid, b_almost_full, b_almost_empty, b_overflow, b_underflow;

   fifo_sync_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(64), .FWFT(1'b0)) u_b (
      .clk(clk), .rst(b_rst), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
      .full(b_full), .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .empty(b_empty), .af_thresh(b_af), .ae_thresh(b_ae), .almost_full(b_almost_full),
      .almost_empty(b_almost_empty), .count(b_count), .free(b_free), .overflow(b_overflow),
      .underflow(b_underflow), .max_count(b_max), .clr_stat(b_clr));

   // ---------------- instance C: FWFT=1, depth 5 ----------------
   logic       c_rst = 1'b1, c_flush = 1'b0, c_wr_en = 1'b0, c_rd_en = 1'b0, c_clr = 1'b0;
   logic [7:0] c_wr_data = '0, c_rd_data;
   logic [3:0] c_af = 4'd0, c_ae = 4'd5, c_count, c_free, c_max;
   logic       c_full, c_empty, c_rd_valid, c_almost_full, c_almost_empty, c_overflow, c_underflow;

   fifo_sync_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1'b1)) u_c (
      .clk(clk), .rst(c_rst), .flush(c_flush), .wr_en(c_wr_en), .wr_data(c_wr_data),
      .full(c_full), .rd_en(c_rd_en), .rd_data(c_rd_data), .rd_valid(c_rd_valid),
      .empty(c_empty), .af_thresh(c_af), .ae_thresh(c_ae), .almost_full(c_almost_full),
      .almost_empty(c_almost_empty), .count(c_count), .free(c_free), .overflow(c_overflow),
      .underflow(c_underflow), .max_count(c_max), .clr_stat(c_clr));

   initial begin
      // ---------------- reset ----------------
      #1;
      tick();
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      check("a_rst_empty", a_empty, 1);
      check("a_rst_full", a_full, 0);
      check("a_rst_free", a_free, 64);
      check("a_rst_count", a_count, 0);
      check("a_rst_max", a_max, 0);
      check("a_rst_ovf", a_overflow, 0);
      check("a_rst_valid", a_rd_valid, 0);
      check("b_rst_valid", b_rd_valid, 0);
      check("b_rst_data", b_rd_data, 0);
      check("b_rst_free", b_free, 64);

      // ---------------- A: fill with thresholds af=60, ae=4 ----------------
      a_af = 7'd60;
      a_ae = 7'd4;
      #1;
      check("a_ae_at0", a_almost_empty, 1);
      for (int i = 0; i < 64; i++) begin
         a_wr_en   = 1'b1;
         a_wr_data = 8'(i);
         tick();
         if (i + 1 == 4)  check("a_ae_at4", a_almost_empty, 1);
         if (i + 1 == 5)  check("a_ae_at5", a_almost_empty, 0);
         if (i + 1 == 59) check("a_af_at59", a_almost_full, 0);
         if (i + 1 == 60) check("a_af_at60", a_almost_full, 1);
         if (i + 1 == 61) begin
            check("a_af_at61", a_almost_full, 1);
            a_af = 7'd62;
            #1;
            check("a_af_raise", a_almost_full, 0);
         end
      end
      a_wr_en = 1'b0;
      check("a_full", a_full, 1);
      check("a_count64", a_count, 64);
      check("a_free0", a_free, 0);
      check("a_max64", a_max, 64);
      check("a_af_full", a_almost_full, 1);

      // 65th write: dropped, sets overflow
      a_wr_en   = 1'b1;
      a_wr_data = 8'hFF;
      tick();
      a_wr_en = 1'b0;
      check("a_ovf_set", a_overflow, 1);
      check("a_ovf_count", a_count, 64);

      // simultaneous wr+rd while full: read accepted, write dropped
      check("a_head0", a_rd_data, 8'h00);
      a_wr_en   = 1'b1;
      a_wr_data = 8'hEE;
      a_rd_en   = 1'b1;
      tick();
      a_wr_en = 1'b0;
      a_rd_en = 1'b0;
      check("a_full_wr_rd_count", a_count, 63);
      check("a_full_wr_rd_ovf", a_overflow, 1);

      // drain remaining 0x01..0x3F in order
      for (int i = 1; i < 64; i++) begin
         check($sformatf("a_rd%0d", i), a_rd_data, i);
         a_rd_en = 1'b1;
         tick();
      end
      a_rd_en = 1'b0;
      check("a_drained_empty", a_empty, 1);
      check("a_drained_valid", a_rd_valid, 0);

      // count=10, simultaneous wr+rd keeps count
      for (int i = 0; i < 10; i++) begin
         a_wr_en   = 1'b1;
         a_wr_data = 8'(8'h80 + i);
         tick();
      end
      a_wr_data = 8'h8A;
      a_rd_en   = 1'b1;
      tick();
      a_wr_en = 1'b0;
      a_rd_en = 1'b0;
      check("a_wr_rd_count10", a_count, 10);
      check("a_wr_rd_head", a_rd_data, 8'h81);

      // ---------------- A: flush and statistics ----------------
      a_rst = 1'b1;
      tick();
      a_rst = 1'b0;
      check("a_rst2_ovf", a_overflow, 0);
      check("a_rst2_max", a_max, 0);
      for (int i = 0; i < 40; i++) begin
         a_wr_en   = 1'b1;
         a_wr_data = 8'(i);
         tick();
      end
      a_flush   = 1'b1;
      a_wr_data = 8'h77;
      tick();
      a_flush = 1'b0;
      a_wr_en = 1'b0;
      check("a_flush_count", a_count, 0);
      check("a_flush_empty", a_empty, 1);
      check("a_flush_ovf", a_overflow, 0);
      check("a_flush_max", a_max, 40);

      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      check("a_clr_max", a_max, 0);

      a_flush = 1'b1;
      a_rd_en = 1'b1;
      tick();
      a_flush = 1'b0;
      a_rd_en = 1'b0;
      check("a_flush_rd_udf", a_underflow, 0);

      a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
      check("a_udf_set", a_underflow, 1);

      a_rd_en = 1'b1;
      a_clr   = 1'b1;
      tick();
      a_rd_en = 1'b0;
      a_clr   = 1'b0;
      check("a_udf_set_wins", a_underflow, 1);

      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      check("a_udf_clr", a_underflow, 0);

      // ---------------- B: registered read ----------------
      b_wr_en   = 1'b1;
      b_wr_data = 8'hA5;
      tick();
      b_wr_data = 8'h5A;
      tick();
      b_wr_en = 1'b0;
      check("b_pre_valid", b_rd_valid, 0);
      b_rd_en = 1'b1;
      tick();
      check("b_rd1_valid", b_rd_valid, 1);
      check("b_rd1_data", b_rd_data, 8'hA5);
      tick();
      b_rd_en = 1'b0;
      check("b_rd2_valid", b_rd_valid, 1);
      check("b_rd2_data", b_rd_data, 8'h5A);
      tick();
      check("b_hold_valid", b_rd_valid, 0);
      check("b_hold_data", b_rd_data, 8'h5A);
      check("b_hold_empty", b_empty, 1);
      b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      check("b_udf_set", b_underflow, 1);
      tick();
      check("b_udf_valid", b_rd_valid, 0);
      check("b_udf_data", b_rd_data, 8'h5A);

      // ---------------- C: depth 5 wrap ----------------
      check("c_af_zero", c_almost_full, 1);
      check("c_ae_depth_at0", c_almost_empty, 1);
      check("c_rst_free", c_free, 5);
      c_wr_en   = 1'b1;
      c_wr_data = 8'h10;
      tick();
      c_wr_data = 8'h11;
      tick();
      for (int i = 0; i < 12; i++) begin
         check($sformatf("c_pair%0d_data", i), c_rd_data,
               (i == 0) ? 32'h10 : (i == 1) ? 32'h11 : 32'(8'h20 + i - 2));
         c_wr_en   = 1'b1;
         c_rd_en   = 1'b1;
         c_wr_data = 8'(8'h20 + i);
         tick();
         check($sformatf("c_pair%0d_count", i), c_count, 2);
      end
      c_rd_en = 1'b0;
      check("c_head_after", c_rd_data, 8'h2A);
      for (int i = 0; i < 3; i++) begin
         c_wr_data = 8'(8'h30 + i);
         tick();
      end
      check("c_full", c_full, 1);
      check("c_free0", c_free, 0);
      check("c_ae_depth_full", c_almost_empty, 1);
      check("c_max5", c_max, 5);
      tick();
      check("c_ovf_set", c_overflow, 1);

      // reset while a write burst is still being requested
      c_rst = 1'b1;
      tick();
      c_rst   = 1'b0;
      c_wr_en = 1'b0;
      check("c_rst_count", c_count, 0);
      check("c_rst_empty", c_empty, 1);
      check("c_rst_full", c_full, 0);
      check("c_rst_ovf", c_overflow, 0);
      check("c_rst_max", c_max, 0);
      check("c_rst_free2", c_free, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
